note_scheduler: RTL

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_scheduler_pkg.sv | 39 +++
 rtl/note_scheduler_if.sv | 31 +++
 rtl/tick_divider.sv | 43 ++++
 rtl/note_scheduler.sv | 120 ++++++++++++
 4 files changed

// File: rtl/note_scheduler_pkg.sv
// rhythm_pkg: shared types and constants for the note scheduler slice.
//   sched_state_t : scheduler FSM state encoding (IDLE/PLAY/PAUSE/OVER)
//   LANES         : number of spawn lanes
//   ROW_PAIRS     : drain ticks needed to flush the 16-row matrix
//   LFSR_TAPS     : Galois mask for x^16+x^14+x^13+x^11
//   lfsr_step     : one Galois LFSR advance
//   spawn_pattern : lane pattern selected by density from an LFSR value
package rhythm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } sched_state_t;

    localparam int unsigned LANES     = 4;
    localparam int unsigned ROW_PAIRS = 8;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    function automatic logic [LANES-1:0] spawn_pattern(input logic [15:0] l,
                                                       input logic [1:0]  density);
        logic [LANES-1:0] p;
        p = '0;
        unique case (density)
            2'd0: p = '0;
            2'd1: p = l[7] ? (4'b0001 << l[1:0]) : '0;
            2'd2: p = l[3:0] & l[7:4];
            2'd3: p = l[3:0];
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// note_scheduler_if: control/status bundle of the note scheduler.
//   start, pause     : one-cycle command pulses (pause toggles PLAY/PAUSE)
//   speed, density   : tempo (higher = faster) and note density
//   en, spawn        : matrix shift tick and lane spawn pulse
//   state, rows_left : FSM state and remaining spawn ticks
//   done             : song finished
// master drives commands, slave is the scheduler.
interface note_scheduler_if;
    import rhythm_pkg::*;

    logic               start;
    logic               pause;
    logic [9:0]         speed;
    logic [1:0]         density;
    logic               en;
    logic [LANES-1:0]   spawn;
    sched_state_t       state;
    logic [7:0]         rows_left;
    logic               done;

    modport master (
        output start, pause, speed, density,
        input  en, spawn, state, rows_left, done
    );

    modport slave (
        input  start, pause, speed, density,
        output en, spawn, state, rows_left, done
    );

endinterface

// File: rtl/tick_divider.sv
// tick_divider: two-stage tempo divider.
//   clk, reset : clock, synchronous active-high reset
//   run        : counters advance only while high
//   clear      : zero both counters
//   reload     : sub-tick period (1..1024), changed only at wrap by the owner
//   tick       : high in the cycle both counters sit at their terminal value
module tick_divider #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        clear,
    input  logic [10:0] reload,
    output logic        tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [10:0]   sub_q;
    logic          presc_end;
    logic          sub_end;

    assign presc_end = (presc_q == PW'(TICK_DIV - 1));
    assign sub_end   = (sub_q == (reload - 11'd1));
    assign tick      = run && !clear && presc_end && sub_end;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            presc_q <= '0;
            sub_q   <= '0;
        end else if (run) begin
            if (presc_end) begin
                presc_q <= '0;
                sub_q   <= sub_end ? '0 : (sub_q + 11'd1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: song FSM driving the falling-note matrix.
//   clk, reset : clock, synchronous active-high reset
//   bus        : note_scheduler_if.slave (start/pause/speed/density in,
//                en/spawn/state/rows_left/done out, all registered)
// Each tempo tick raises en for one cycle; the lane pattern chosen on that
// tick is emitted on spawn the following cycle so a spawn never lands on a
// shift. After the last spawn tick, ROW_PAIRS drain ticks flush the matrix.
module note_scheduler
    import rhythm_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned SONG_ROWS = 200,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    note_scheduler_if.slave     bus
);

    localparam int unsigned DW = $clog2(ROW_PAIRS);

    sched_state_t       state_q;
    logic [15:0]        lfsr_q;
    logic [7:0]         rows_q;
    logic               drain_q;
    logic [DW-1:0]      drain_cnt_q;
    logic               parity_q;
    logic [10:0]        reload_q;
    logic [LANES-1:0]   pend_q;
    logic               en_q;
    logic [LANES-1:0]   spawn_q;
    logic               done_q;

    logic               start_go;
    logic               run;
    logic               tick;
    logic [10:0]        speed_reload;
    logic [15:0]        lfsr_next;

    assign start_go     = bus.start && (state_q == IDLE || state_q == OVER);
    assign run          = (state_q == PLAY);
    assign speed_reload = 11'd1024 - {1'b0, bus.speed};
    assign lfsr_next    = lfsr_step(lfsr_q);

    tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .clear  (start_go),
        .reload (reload_q),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            rows_q      <= '0;
            drain_q     <= 1'b0;
            drain_cnt_q <= '0;
            parity_q    <= 1'b0;
            reload_q    <= 11'd1024;
            pend_q      <= '0;
            en_q        <= 1'b0;
            spawn_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            en_q    <= 1'b0;
            spawn_q <= '0;
            if (start_go) begin
                state_q     <= PLAY;
                lfsr_q      <= LFSR_SEED;
                rows_q      <= 8'(SONG_ROWS);
                drain_q     <= 1'b0;
                drain_cnt_q <= '0;
                parity_q    <= 1'b0;
                reload_q    <= speed_reload;
                pend_q      <= '0;
                done_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    PLAY: begin
                        if (bus.pause) state_q <= PAUSE;
                        // pattern chosen on the previous tick goes out now;
                        // a pending pattern survives a pause
                        spawn_q <= pend_q;
                        pend_q  <= '0;
                        if (tick) begin
                            en_q     <= 1'b1;
                            reload_q <= speed_reload;
                            parity_q <= ~parity_q;
                            if (!drain_q) begin
                                lfsr_q <= lfsr_next;
                                rows_q <= (rows_q == 8'd0) ? 8'd0 : (rows_q - 8'd1);
                                if (rows_q <= 8'd1) drain_q <= 1'b1;
                                pend_q <= parity_q ? '0 : spawn_pattern(lfsr_next, bus.density);
                            end else if (drain_cnt_q == DW'(ROW_PAIRS - 1)) begin
                                state_q <= OVER;
                                done_q  <= 1'b1;
                            end else begin
                                drain_cnt_q <= drain_cnt_q + DW'(1);
                            end
                        end
                    end
                    PAUSE: begin
                        if (bus.pause) state_q <= PLAY;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.en        = en_q;
    assign bus.spawn     = spawn_q;
    assign bus.state     = state_q;
    assign bus.rows_left = rows_q;
    assign bus.done      = done_q;

endmodule
